// File: rtl/udp_rx.sv
// UDP receive stage: parses the 8-byte UDP header from the IPv4 payload stream,
// filters and length-checks the datagram, and forwards user data with last-byte marking.
module udp_rx #(
  parameter bit          PORT_FILTER_EN = 1'b0,
  parameter logic [15:0] FILTER_PORT    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_rx_start,
  input  logic        ip_rx_hdr_is_valid,
  input  logic [7:0]  ip_rx_protocol,
  input  logic [15:0] ip_rx_data_length,
  input  logic [31:0] ip_rx_src_ip,
  input  logic [7:0]  ip_rx_data_in,
  input  logic        ip_rx_data_in_valid,
  input  logic        ip_rx_data_in_last,
  output logic        udp_rx_start,
  output logic [31:0] udp_rx_src_ip,
  output logic [15:0] udp_rx_src_port,
  output logic [15:0] udp_rx_dst_port,
  output logic [15:0] udp_rx_data_length,
  output logic [7:0]  udp_rx_data_out,
  output logic        udp_rx_data_out_valid,
  output logic        udp_rx_data_out_last,
  output logic        udp_rx_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  hdr_cnt_reg;
  logic [47:0] hdr_sr_reg;
  logic [15:0] rem_reg;
  logic [15:0] ip_len_reg;
  logic [31:0] src_ip_reg;

  logic        start_reg, err_reg, out_valid_reg, out_last_reg;
  logic [31:0] src_ip_out_reg;
  logic [15:0] src_port_reg, dst_port_reg, data_length_reg;
  logic [7:0]  data_out_reg;

  logic        start_next, err_next, beat_next, beat_last_next;
  logic        accept, in_last, hdr_byte, hdr_pass;
  logic [15:0] udp_len;

  assign accept   = ip_rx_start && ip_rx_hdr_is_valid && (ip_rx_protocol == 8'h11);
  assign in_last  = ip_rx_data_in_valid && ip_rx_data_in_last;
  assign hdr_byte = ip_rx_data_in_valid && ((state_reg == HDR) || ((state_reg == IDLE) && accept));
  // Only bytes 0-5 are kept; the checksum is never inspected.
  assign udp_len  = hdr_sr_reg[15:0];
  assign hdr_pass = (udp_len >= 16'd8) && (udp_len <= ip_len_reg) &&
                    (!PORT_FILTER_EN || (hdr_sr_reg[31:16] == FILTER_PORT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ip_rx_start) state_next = in_last ? IDLE : (accept ? HDR : DROP);
      HDR: begin
        if (hdr_byte) begin
          if (in_last)
            state_next = IDLE;
          else if (hdr_cnt_reg == 3'd7)
            state_next = (hdr_pass && (udp_len != 16'd8)) ? DATA : DROP;
        end
      end
      DATA: begin
        if (ip_rx_data_in_valid) begin
          if (in_last)                 state_next = IDLE;
          else if (rem_reg == 16'd1)   state_next = DROP;
        end
      end
      DROP:    if (in_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_next     = 1'b0;
    err_next       = 1'b0;
    beat_next      = 1'b0;
    beat_last_next = 1'b0;
    case (state_reg)
      IDLE: err_next = accept && in_last;
      HDR: begin
        if (hdr_byte) begin
          if (hdr_cnt_reg != 3'd7) begin
            err_next = in_last;
          end else begin
            start_next = hdr_pass;
            err_next   = !hdr_pass || (in_last && (udp_len != 16'd8));
          end
        end
      end
      DATA: begin
        if (ip_rx_data_in_valid) begin
          beat_next      = 1'b1;
          beat_last_next = in_last || (rem_reg == 16'd1);
          err_next       = in_last && (rem_reg != 16'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_cnt_reg     <= '0;
      hdr_sr_reg      <= '0;
      rem_reg         <= '0;
      ip_len_reg      <= '0;
      src_ip_reg      <= '0;
      start_reg       <= 1'b0;
      err_reg         <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      src_ip_out_reg  <= '0;
      src_port_reg    <= '0;
      dst_port_reg    <= '0;
      data_length_reg <= '0;
      data_out_reg    <= '0;
    end else begin
      start_reg     <= start_next;
      err_reg       <= err_next;
      out_valid_reg <= beat_next;
      out_last_reg  <= beat_last_next;
      if ((state_reg == IDLE) && accept) begin
        src_ip_reg <= ip_rx_src_ip;
        ip_len_reg <= ip_rx_data_length;
      end
      // Counter is cleared whenever we leave HDR so byte 0 may arrive with the start pulse.
      hdr_cnt_reg <= (state_next == HDR) ? hdr_cnt_reg + {2'b00, hdr_byte} : 3'd0;
      if (hdr_byte && (hdr_cnt_reg < 3'd6))
        hdr_sr_reg <= {hdr_sr_reg[39:0], ip_rx_data_in};
      if (start_next) begin
        src_ip_out_reg  <= src_ip_reg;
        src_port_reg    <= hdr_sr_reg[47:32];
        dst_port_reg    <= hdr_sr_reg[31:16];
        data_length_reg <= udp_len - 16'd8;
        rem_reg         <= udp_len - 16'd8;
      end else if (beat_next) begin
        rem_reg <= rem_reg - 16'd1;
      end
      if (beat_next)
        data_out_reg <= ip_rx_data_in;
    end
  end

  assign udp_rx_start          = start_reg;
  assign udp_rx_src_ip         = src_ip_out_reg;
  assign udp_rx_src_port       = src_port_reg;
  assign udp_rx_dst_port       = dst_port_reg;
  assign udp_rx_data_length    = data_length_reg;
  assign udp_rx_data_out       = data_out_reg;
  assign udp_rx_data_out_valid = out_valid_reg;
  assign udp_rx_data_out_last  = out_last_reg;
  assign udp_rx_err            = err_reg;

endmodule

// File: tb/tb_udp_rx.sv
// Bench for udp_rx: directed table, reset-abort sequence and randomized datagrams
// against a datagram-level reference model, on an unfiltered and a port-53-filtered instance.
module tb_udp_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        ip_rx_start, ip_rx_hdr_is_valid, ip_rx_data_in_valid, ip_rx_data_in_last;
  logic [7:0]  ip_rx_protocol, ip_rx_data_in;
  logic [15:0] ip_rx_data_length;
  logic [31:0] ip_rx_src_ip;

  logic        o_start [2];
  logic [31:0] o_ip    [2];
  logic [15:0] o_sp    [2];
  logic [15:0] o_dp    [2];
  logic [15:0] o_dl    [2];
  logic [7:0]  o_data  [2];
  logic        o_valid [2];
  logic        o_last  [2];
  logic        o_err   [2];

  always #5 clk = ~clk;

  udp_rx dut (
    .clk(clk), .reset(reset),
    .ip_rx_start(ip_rx_start), .ip_rx_hdr_is_valid(ip_rx_hdr_is_valid),
    .ip_rx_protocol(ip_rx_protocol), .ip_rx_data_length(ip_rx_data_length),
    .ip_rx_src_ip(ip_rx_src_ip), .ip_rx_data_in(ip_rx_data_in),
    .ip_rx_data_in_valid(ip_rx_data_in_valid), .ip_rx_data_in_last(ip_rx_data_in_last),
    .udp_rx_start(o_start[0]), .udp_rx_src_ip(o_ip[0]), .udp_rx_src_port(o_sp[0]),
    .udp_rx_dst_port(o_dp[0]), .udp_rx_data_length(o_dl[0]), .udp_rx_data_out(o_data[0]),
    .udp_rx_data_out_valid(o_valid[0]), .udp_rx_data_out_last(o_last[0]), .udp_rx_err(o_err[0])
  );

  udp_rx #(.PORT_FILTER_EN(1'b1), .FILTER_PORT(16'd53)) dut_f (
    .clk(clk), .reset(reset),
    .ip_rx_start(ip_rx_start), .ip_rx_hdr_is_valid(ip_rx_hdr_is_valid),
    .ip_rx_protocol(ip_rx_protocol), .ip_rx_data_length(ip_rx_data_length),
    .ip_rx_src_ip(ip_rx_src_ip), .ip_rx_data_in(ip_rx_data_in),
    .ip_rx_data_in_valid(ip_rx_data_in_valid), .ip_rx_data_in_last(ip_rx_data_in_last),
    .udp_rx_start(o_start[1]), .udp_rx_src_ip(o_ip[1]), .udp_rx_src_port(o_sp[1]),
    .udp_rx_dst_port(o_dp[1]), .udp_rx_data_length(o_dl[1]), .udp_rx_data_out(o_data[1]),
    .udp_rx_data_out_valid(o_valid[1]), .udp_rx_data_out_last(o_last[1]), .udp_rx_err(o_err[1])
  );

  typedef struct {
    bit          start;
    logic [15:0] dl;
    int          beats;
    bit          err;
    int          err_at;   // input byte index whose cycle+1 carries the err pulse
  } exp_t;

  typedef struct {
    logic [7:0]  proto;
    bit          hv;
    logic [15:0] ip_len, ul, sp, dp;
    int          n;
    bit          coin, gaps;
    exp_t        e0, e1;
  } vec_t;

  typedef struct {
    int          inst, kind, cyc;
    logic [7:0]  data;
    logic        last;
    logic [15:0] sp, dp, dl;
    logic [31:0] ip;
  } ev_t;

  int         tests = 0, failed = 0, cyc = 0;
  ev_t        ev_q[$];
  logic [7:0] tx_bytes[64];
  int         tx_cyc[64];
  vec_t       vecs[11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (o_start[i]) ev_q.push_back('{i, 0, cyc, 8'h0, 1'b0, o_sp[i], o_dp[i], o_dl[i], o_ip[i]});
        if (o_valid[i]) ev_q.push_back('{i, 1, cyc, o_data[i], o_last[i], 16'h0, 16'h0, 16'h0, 32'h0});
        if (o_err[i])   ev_q.push_back('{i, 2, cyc, 8'h0, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0});
        if (o_last[i] && !o_valid[i]) ev_q.push_back('{i, 3, cyc, 8'h0, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(bit s, int dl, int b, bit er, int at);
    exp_t e;
    e.start = s; e.dl = 16'(dl); e.beats = b; e.err = er; e.err_at = at;
    return e;
  endfunction

  // Reference model: outcome of one datagram from the header rules and the byte count.
  function automatic exp_t model(logic [7:0] proto, bit hv, logic [15:0] ip_len, int n, bit filt);
    exp_t        e = mk(0, 0, 0, 0, 0);
    logic [15:0] ul, dp;
    int          d;
    if (!(hv && proto == 8'h11)) return e;
    if (n < 8) return mk(0, 0, 0, 1, n - 1);
    ul = {tx_bytes[4], tx_bytes[5]};
    dp = {tx_bytes[2], tx_bytes[3]};
    if (ul < 16'd8 || ul > ip_len || (filt && dp != 16'd53)) return mk(0, 0, 0, 1, 7);
    d = int'(ul) - 8;
    if (n - 8 < d) return mk(1, d, n - 8, 1, n - 1);
    return mk(1, d, d, 0, 0);
  endfunction

  task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ul, input bit rnd);
    tx_bytes[0] = sp[15:8]; tx_bytes[1] = sp[7:0];
    tx_bytes[2] = dp[15:8]; tx_bytes[3] = dp[7:0];
    tx_bytes[4] = ul[15:8]; tx_bytes[5] = ul[7:0];
    tx_bytes[6] = rnd ? 8'($urandom) : 8'h00;
    tx_bytes[7] = rnd ? 8'($urandom) : 8'h00;
    for (int i = 8; i < 64; i++) tx_bytes[i] = rnd ? 8'($urandom) : 8'(8'hAA + (i - 8) * 17);
  endtask

  task automatic junk();
    ip_rx_start        = 1'b0;
    ip_rx_hdr_is_valid = 1'($urandom);
    ip_rx_protocol     = 8'($urandom);
    ip_rx_data_length  = 16'($urandom);
    ip_rx_src_ip       = $urandom;
  endtask

  task automatic drive_byte(input int i, input int n, input bit mark_last);
    ip_rx_data_in       = tx_bytes[i];
    ip_rx_data_in_valid = 1'b1;
    ip_rx_data_in_last  = mark_last && (i == n - 1);
    tx_cyc[i]           = cyc;
  endtask

  task automatic send(input logic [7:0] proto, input bit hv, input logic [15:0] ip_len,
                      input logic [31:0] sip, input int n, input bit coin, input bit gaps,
                      input bit mark_last);
    int idx = 0;
    @(posedge clk); #1;
    ip_rx_start = 1'b1; ip_rx_hdr_is_valid = hv; ip_rx_protocol = proto;
    ip_rx_data_length = ip_len; ip_rx_src_ip = sip;
    if (coin) begin
      drive_byte(0, n, mark_last);
      idx = 1;
    end else begin
      ip_rx_data_in_valid = 1'b0; ip_rx_data_in_last = 1'b0;
    end
    while (idx < n) begin
      @(posedge clk); #1; junk();
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ip_rx_data_in_valid = 1'b0; ip_rx_data_in_last = 1'b0; ip_rx_data_in = 8'($urandom);
          @(posedge clk); #1; junk();
        end
      end
      drive_byte(idx, n, mark_last);
      idx++;
    end
    @(posedge clk); #1; junk();
    ip_rx_data_in_valid = 1'b0; ip_rx_data_in_last = 1'b0;
  endtask

  task automatic check_inst(input int inst, input exp_t e, input logic [31:0] sip, input string tag);
    ev_t st[$], bt[$], er[$];
    int  stray = 0;
    foreach (ev_q[k]) begin
      if (ev_q[k].inst == inst) begin
        case (ev_q[k].kind)
          0:       st.push_back(ev_q[k]);
          1:       bt.push_back(ev_q[k]);
          2:       er.push_back(ev_q[k]);
          default: stray++;
        endcase
      end
    end
    chk($sformatf("%s.starts", tag), 32'(st.size()), 32'(e.start));
    if (st.size() == 1 && e.start) begin
      chk($sformatf("%s.src_port", tag), 32'(st[0].sp), 32'({tx_bytes[0], tx_bytes[1]}));
      chk($sformatf("%s.dst_port", tag), 32'(st[0].dp), 32'({tx_bytes[2], tx_bytes[3]}));
      chk($sformatf("%s.data_len", tag), 32'(st[0].dl), 32'(e.dl));
      chk($sformatf("%s.src_ip", tag), st[0].ip, sip);
      chk($sformatf("%s.start_cyc", tag), 32'(st[0].cyc), 32'(tx_cyc[7] + 1));
    end
    chk($sformatf("%s.beats", tag), 32'(bt.size()), 32'(e.beats));
    for (int j = 0; j < bt.size() && j < e.beats; j++) begin
      chk($sformatf("%s.data[%0d]", tag, j), 32'(bt[j].data), 32'(tx_bytes[8 + j]));
      chk($sformatf("%s.last[%0d]", tag, j), 32'(bt[j].last), 32'(j == e.beats - 1));
      chk($sformatf("%s.beat_cyc[%0d]", tag, j), 32'(bt[j].cyc), 32'(tx_cyc[8 + j] + 1));
    end
    chk($sformatf("%s.errs", tag), 32'(er.size()), 32'(e.err));
    if (er.size() == 1 && e.err)
      chk($sformatf("%s.err_cyc", tag), 32'(er[0].cyc), 32'(tx_cyc[e.err_at] + 1));
    chk($sformatf("%s.stray_last", tag), 32'(stray), 32'd0);
  endtask

  task automatic check_dgram(input exp_t e0, input exp_t e1, input logic [31:0] sip, input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_inst(0, e0, sip, {tag, "/nf"});
    check_inst(1, e1, sip, {tag, "/pf"});
    ev_q.delete();
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s%0d.start", tag, i), 32'(o_start[i]), 32'd0);
      chk($sformatf("%s%0d.valid", tag, i), 32'(o_valid[i]), 32'd0);
      chk($sformatf("%s%0d.last", tag, i), 32'(o_last[i]), 32'd0);
      chk($sformatf("%s%0d.err", tag, i), 32'(o_err[i]), 32'd0);
      chk($sformatf("%s%0d.data", tag, i), 32'(o_data[i]), 32'd0);
      chk($sformatf("%s%0d.hdr", tag, i), 32'(o_sp[i] | o_dp[i] | o_dl[i]) | o_ip[i], 32'd0);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  proto;
    logic [15:0] ul, ip_len, sp, dp;
    logic [31:0] sip;
    bit          hv, coin, gaps;
    int          n, d, kind, m;
    exp_t        e0, e1;

    reset = 1'b0;
    ip_rx_start = 1'b0; ip_rx_hdr_is_valid = 1'b0; ip_rx_protocol = 8'h0;
    ip_rx_data_length = 16'h0; ip_rx_src_ip = 32'h0; ip_rx_data_in = 8'h0;
    ip_rx_data_in_valid = 1'b0; ip_rx_data_in_last = 1'b0;

    //          proto  hv    ip_len  udp_len sp        dp      n   coin  gaps  unfiltered            filtered(53)
    vecs[0]  = '{8'h11, 1'b1, 16'd12, 16'd12, 16'd1234, 16'd53, 12, 1'b1, 1'b0, mk(1, 4, 4, 0, 0),  mk(1, 4, 4, 0, 0)};
    vecs[1]  = '{8'h11, 1'b1, 16'd46, 16'd10, 16'd1000, 16'd53, 46, 1'b0, 1'b0, mk(1, 2, 2, 0, 0),  mk(1, 2, 2, 0, 0)};
    vecs[2]  = '{8'h06, 1'b1, 16'd20, 16'd20, 16'd1,    16'd53, 20, 1'b1, 1'b0, mk(0, 0, 0, 0, 0),  mk(0, 0, 0, 0, 0)};
    vecs[3]  = '{8'h11, 1'b1, 16'd20, 16'd6,  16'd7,    16'd53, 20, 1'b0, 1'b0, mk(0, 0, 0, 1, 7),  mk(0, 0, 0, 1, 7)};
    vecs[4]  = '{8'h11, 1'b1, 16'd20, 16'h40, 16'd7,    16'd53, 20, 1'b1, 1'b0, mk(0, 0, 0, 1, 7),  mk(0, 0, 0, 1, 7)};
    vecs[5]  = '{8'h11, 1'b1, 16'd20, 16'd20, 16'd9,    16'd53, 13, 1'b0, 1'b0, mk(1, 12, 5, 1, 12), mk(1, 12, 5, 1, 12)};
    vecs[6]  = '{8'h11, 1'b1, 16'd10, 16'd8,  16'd5,    16'd53, 10, 1'b1, 1'b0, mk(1, 0, 0, 0, 0),  mk(1, 0, 0, 0, 0)};
    vecs[7]  = '{8'h11, 1'b1, 16'd12, 16'd12, 16'd4000, 16'd80, 12, 1'b0, 1'b0, mk(1, 4, 4, 0, 0),  mk(0, 0, 0, 1, 7)};
    vecs[8]  = '{8'h11, 1'b0, 16'd12, 16'd12, 16'd4000, 16'd53, 12, 1'b1, 1'b0, mk(0, 0, 0, 0, 0),  mk(0, 0, 0, 0, 0)};
    vecs[9]  = '{8'h11, 1'b1, 16'd12, 16'd12, 16'd4000, 16'd53, 4,  1'b0, 1'b0, mk(0, 0, 0, 1, 3),  mk(0, 0, 0, 1, 3)};
    vecs[10] = '{8'h11, 1'b1, 16'd12, 16'd12, 16'd1234, 16'd53, 12, 1'b0, 1'b1, mk(1, 4, 4, 0, 0),  mk(1, 4, 4, 0, 0)};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      build(vecs[i].sp, vecs[i].dp, vecs[i].ul, 1'b0);
      sip = 32'hC0A8_0001 + 32'(i);
      send(vecs[i].proto, vecs[i].hv, vecs[i].ip_len, sip, vecs[i].n, vecs[i].coin, vecs[i].gaps, 1'b1);
      check_dgram(vecs[i].e0, vecs[i].e1, sip, $sformatf("vec%0d", i));
    end

    // Reset asserted while user data is streaming, then a clean datagram.
    build(16'd7, 16'd53, 16'd30, 1'b0);
    send(8'h11, 1'b1, 16'd30, 32'h0A00_0001, 18, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ev_q.delete();
    build(16'd1234, 16'd53, 16'd12, 1'b0);
    send(8'h11, 1'b1, 16'd12, 32'h0A00_0002, 12, 1'b0, 1'b0, 1'b1);
    check_dgram(mk(1, 4, 4, 0, 0), mk(1, 4, 4, 0, 0), 32'h0A00_0002, "post_rst");

    for (int t = 0; t < 150; t++) begin
      proto = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11;
      hv    = ($urandom_range(0, 9) != 0);
      kind  = $urandom_range(0, 9);
      d     = 0;
      if (kind < 7) begin
        d = $urandom_range(0, 20);
        ul = 16'(d + 8);
        ip_len = ul + 16'($urandom_range(0, 6));
      end else if (kind == 7) begin
        ul = 16'($urandom_range(0, 7));
        ip_len = 16'($urandom_range(8, 30));
      end else begin
        ip_len = 16'($urandom_range(8, 30));
        ul = ip_len + 16'($urandom_range(1, 10));
      end
      n = int'(ip_len);
      m = $urandom_range(0, 5);
      if (m == 0) n = $urandom_range(1, 7);
      else if (m == 1 && d >= 2) n = $urandom_range(9, 7 + d);
      sp   = 16'($urandom);
      dp   = ($urandom_range(0, 1) != 0) ? 16'd53 : 16'($urandom);
      sip  = $urandom;
      coin = 1'($urandom);
      gaps = 1'($urandom);
      build(sp, dp, ul, 1'b1);
      send(proto, hv, ip_len, sip, n, coin, gaps, 1'b1);
      e0 = model(proto, hv, ip_len, n, 1'b0);
      e1 = model(proto, hv, ip_len, n, 1'b1);
      check_dgram(e0, e1, sip, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
